handshake_ctrl_from_data: RTL

Elastic data-to-control converter for the dataflow circuit: consumes tokens on a data channel and emits one dataless control token per accepted input. It is the counterpart of the constant unit, which turns a control token into a constant-valued data token. This block sits where a constant or data result must be collapsed back into a control edge, for example to trigger a downstream constant, join or memory controller. A small occupancy-counter buffer decouples the input and output handshakes. An optional checker compares every accepted value against an expected constant and latches the first mismatch.

---
 rtl/handshake_ctrl_from_data.sv | 108 ++++++++++
 1 files changed

// File: rtl/handshake_ctrl_from_data.sv
// Elastic data-to-control converter: one dataless control token out per
// accepted data token in, decoupled by an occupancy-counter buffer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ins, ins_valid      input data channel
//   ins_ready           input may be accepted (never from outs_ready)
//   outs_valid          control token pending (registered-derived)
//   outs_ready          consumer takes the control token
//   token_count         inputs accepted since reset, wraps
//   mismatch            sticky: an accepted value differed from EXPECTED
//   mismatch_value      first offending input value
//
// Build option: define HANDSHAKE_CTRL_CHECK_EN to build the value checker;
// otherwise mismatch and mismatch_value are tied to zero.

module handshake_ctrl_from_data #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned EXPECTED    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  ins,
    input  logic                   ins_valid,
    output logic                   ins_ready,
    output logic                   outs_valid,
    input  logic                   outs_ready,
    output logic [COUNT_WIDTH-1:0] token_count,
    output logic                   mismatch,
    output logic [DATA_WIDTH-1:0]  mismatch_value
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

    // Truncate or zero-extend the reference value to the data width.
    localparam logic [DATA_WIDTH-1:0] EXP_V = DATA_WIDTH'(EXPECTED);

    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_nxt;
    logic             acc;
    logic             emt;

    // Ready looks only at local state, so the ready path stays broken.
    assign ins_ready  = !rst && (occ != OCC_FULL);
    assign outs_valid = (occ != '0);

    assign acc = ins_valid & ins_ready;
    assign emt = outs_valid & outs_ready;

    always_comb begin
        occ_nxt = occ;
        unique case (1'b1)
            acc && !emt: occ_nxt = occ + OCC_ONE;
            emt && !acc: occ_nxt = occ - OCC_ONE;
            default:     occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else begin
            occ <= occ_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            token_count <= '0;
        end else if (acc) begin
            token_count <= token_count + COUNT_WIDTH'(1);
        end
    end

`ifdef HANDSHAKE_CTRL_CHECK_EN

    logic mis_hit;

    // Only the first differing value is captured.
    assign mis_hit = acc && !mismatch && (ins != EXP_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch       <= 1'b0;
            mismatch_value <= '0;
        end else if (mis_hit) begin
            mismatch       <= 1'b1;
            mismatch_value <= ins;
        end
    end

`else

    assign mismatch       = 1'b0;
    assign mismatch_value = '0;

    // Data is not inspected in this build.
    logic unused_ins;
    assign unused_ins = ^{ins, EXP_V};

`endif

endmodule
